fetch_stage: RTL

Instruction fetch front end that feeds `core`. It holds the PC and issues word requests to instruction memory. Returned instructions go into a 2-entry buffer, which presents {pc, instr} to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and any in-flight fetch.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 111 +++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage memory, redirect and decode handshake bundle
// master is the fetch stage; slave is the memory/execute/decode side.
interface fetch_stage_if #(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [BUS_WIDTH-1:0]   imem_req_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;
  logic                   redirect_valid;
  logic [BUS_WIDTH-1:0]   redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [BUS_WIDTH-1:0]   out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end with 2-entry output buffer
// One outstanding imem request; redirects flush the buffer and drop any in-flight response.
module fetch_stage #(
  parameter int                   BUS_WIDTH   = 64,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC    = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   pc_q, pc_d;
  logic [BUS_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [1:0]             count_q, count_d;
  logic                   head_q, head_d;
  logic [BUS_WIDTH-1:0]   buf_pc_q    [2];
  logic [BUS_WIDTH-1:0]   buf_pc_d    [2];
  logic [INSTR_WIDTH-1:0] buf_instr_q [2];
  logic [INSTR_WIDTH-1:0] buf_instr_d [2];

  logic req_valid;
  logic req_fire;
  logic push;
  logic pop;
  logic tail;
  logic out_valid;

  assign req_valid = (state_q == ST_RUN) && (count_q < 2'd2) && !bus.redirect_valid && !rst;
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign push      = (state_q == ST_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
  // With one entry held the free slot is the other one; with zero it is the head.
  assign tail      = head_q ^ (count_q == 2'd1);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;

    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[BUS_WIDTH-1:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
      if (state_q == ST_WAIT) begin
        state_d = bus.imem_resp_valid ? ST_RUN : ST_DROP;
      end else if ((state_q == ST_DROP) && bus.imem_resp_valid) begin
        state_d = ST_RUN;
      end
    end else begin
      if (req_fire) begin
        pc_d          = pc_q + BUS_WIDTH'(4);
        inflight_pc_d = pc_q;
        state_d       = ST_WAIT;
      end
      // A response while in RUN is a protocol error and is ignored.
      if (bus.imem_resp_valid && (state_q != ST_RUN)) begin
        state_d = ST_RUN;
      end
      if (push) begin
        buf_pc_d[tail]    = inflight_pc_q;
        buf_instr_d[tail] = bus.imem_resp_data;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
    end
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = out_valid ? buf_pc_q[head_q] : '0;
  assign bus.out_instr      = out_valid ? buf_instr_q[head_q] : '0;

endmodule
